// File: rtl/weapons_array.sv
// Multi-channel weapons controller: per-channel ammo counter with capacity,
// fire-rate decrement, post-shot cooldown and timed reload.
module weapons_array #(
   parameter int NCH        = 4,
   parameter int AW         = 9,
   parameter int CDW        = 4,
   parameter int RELOAD_CYC = 8,
   parameter int SW         = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        mode_selector,
   input  logic [SW-1:0]     sel,
   input  logic              fire,
   input  logic              load_max,
   input  logic [AW-1:0]     max_in,
   input  logic              reload_req,
   input  logic [AW-1:0]     reload_amt,
   input  logic [AW-1:0]     fire_rate,
   input  logic [CDW-1:0]    cooldown,
   output logic [NCH*AW-1:0] ammo,
   output logic [NCH-1:0]    busy,
   output logic              fired,
   output logic              error
);

   localparam int RCW = (RELOAD_CYC > 1) ? $clog2(RELOAD_CYC) : 1;
   localparam int TW  = (RCW > CDW) ? RCW : CDW;

   typedef enum logic [1:0] {IDLE = 2'd0, COOL = 2'd1, RELOAD = 2'd2} ch_state_e;

   logic [NCH-1:0] ready;
   logic           sel_ready;
   logic           fire_ok;
   logic           fired_reg;
   logic           error_reg;

   // An out-of-range sel matches no channel, so it can never be ready.
   always_comb begin
      sel_ready = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         if (sel == SW'(i)) sel_ready = ready[i];
      end
   end

   assign fire_ok = fire && (mode_selector == 4'b0010) && !load_max && !reload_req && sel_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fired_reg <= 1'b0;
         error_reg <= 1'b0;
      end else begin
         fired_reg <= fire_ok;
         error_reg <= fire && !fire_ok;
      end
   end

   assign fired = fired_reg;
   assign error = error_reg;

   for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      ch_state_e     state_reg, state_next;
      logic [TW-1:0] timer_reg, timer_next;
      logic [AW-1:0] ammo_reg, ammo_next;
      logic [AW-1:0] cap_reg, cap_next;
      logic [AW-1:0] amt_reg, amt_next;
      logic [AW-1:0] cap_eff;
      logic [AW:0]   reload_sum;
      logic          hit, do_load, do_reload, do_fire;

      assign hit       = (sel == SW'(gi));
      assign do_load   = hit && load_max;
      assign do_reload = hit && reload_req && !load_max && (state_reg == IDLE);
      assign do_fire   = hit && fire_ok;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            state_reg <= IDLE;
            timer_reg <= '0;
            ammo_reg  <= '0;
            cap_reg   <= '0;
            amt_reg   <= '0;
         end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            ammo_reg  <= ammo_next;
            cap_reg   <= cap_next;
            amt_reg   <= amt_next;
         end
      end

      always_comb begin
         state_next = state_reg;
         timer_next = timer_reg;
         ammo_next  = ammo_reg;
         cap_next   = cap_reg;
         amt_next   = amt_reg;
         // A reload finishing on the same edge as a load_max honours the new capacity.
         cap_eff    = do_load ? max_in : cap_reg;
         reload_sum = {1'b0, ammo_reg} + {1'b0, amt_reg};
         case (state_reg)
            IDLE: begin
               if (do_reload) begin
                  state_next = RELOAD;
                  timer_next = TW'(RELOAD_CYC - 1);
                  amt_next   = reload_amt;
               end else if (do_fire) begin
                  ammo_next = (ammo_reg > fire_rate) ? ammo_reg - fire_rate : '0;
                  if (cooldown != '0) begin
                     state_next = COOL;
                     timer_next = TW'(cooldown - CDW'(1));
                  end
               end
            end
            COOL: begin
               if (timer_reg == '0) state_next = IDLE;
               else                 timer_next = timer_reg - TW'(1);
            end
            RELOAD: begin
               if (timer_reg == '0) begin
                  state_next = IDLE;
                  ammo_next  = (reload_sum > {1'b0, cap_eff}) ? cap_eff : reload_sum[AW-1:0];
               end else begin
                  timer_next = timer_reg - TW'(1);
               end
            end
            default: state_next = IDLE;
         endcase
         if (do_load) begin
            cap_next = max_in;
            if (ammo_next > max_in) ammo_next = max_in;
         end
      end

      assign ready[gi]          = (state_reg == IDLE) && (ammo_reg != '0);
      assign busy[gi]           = (state_reg != IDLE);
      assign ammo[gi*AW +: AW]  = ammo_reg;
   end

endmodule

// File: tb/tb_weapons_array.sv
// Directed bench for weapons_array: reload, fire/cooldown, priority, clamp,
// out-of-range select (3-channel copy) and asynchronous reset.
module tb_weapons_array;
   localparam int AW = 9;
   localparam int CDW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [3:0]    mode_selector = '0;
   logic [1:0]    sel = '0;
   logic          fire = 1'b0;
   logic          load_max = 1'b0;
   logic [AW-1:0] max_in = '0;
   logic          reload_req = 1'b0;
   logic [AW-1:0] reload_amt = '0;
   logic [AW-1:0] fire_rate = '0;
   logic [CDW-1:0] cooldown = '0;

   logic [4*AW-1:0] ammo;
   logic [3:0]      busy;
   logic            fired, error;
   logic [3*AW-1:0] ammo3;
   logic [2:0]      busy3;
   logic            fired3, error3;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   weapons_array #(.NCH(4), .AW(AW), .CDW(CDW), .RELOAD_CYC(8)) dut (
      .clk(clk), .rst(rst), .mode_selector(mode_selector), .sel(sel), .fire(fire),
      .load_max(load_max), .max_in(max_in), .reload_req(reload_req), .reload_amt(reload_amt),
      .fire_rate(fire_rate), .cooldown(cooldown), .ammo(ammo), .busy(busy),
      .fired(fired), .error(error)
   );

   weapons_array #(.NCH(3), .AW(AW), .CDW(CDW), .RELOAD_CYC(8)) dut3 (
      .clk(clk), .rst(rst), .mode_selector(mode_selector), .sel(sel), .fire(fire),
      .load_max(load_max), .max_in(max_in), .reload_req(reload_req), .reload_amt(reload_amt),
      .fire_rate(fire_rate), .cooldown(cooldown), .ammo(ammo3), .busy(busy3),
      .fired(fired3), .error(error3)
   );

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end else begin
         $display("ok   %s: %0d", tag, act);
      end
   endtask

   function automatic logic [AW-1:0] ammo_of(input int ch);
      return ammo[ch*AW +: AW];
   endfunction

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input int ch, input int val);
      sel = 2'(ch); max_in = AW'(val); load_max = 1'b1;
      cycle();
      load_max = 1'b0;
   endtask

   task automatic do_reload(input int ch, input int amt);
      sel = 2'(ch); reload_amt = AW'(amt); reload_req = 1'b1;
      cycle();
      reload_req = 1'b0;
   endtask

   task automatic do_fire(input int ch);
      sel = 2'(ch); fire = 1'b1;
      cycle();
      fire = 1'b0;
   endtask

   initial begin
      #2 rst = 1'b0;
      cycle();
      cycle();
      check_val("rst_ammo", 32'(ammo), 0);
      check_val("rst_busy", 32'(busy), 0);
      check_val("rst_fired_error", {30'd0, fired, error}, 0);
      #2 rst = 1'b1;
      cycle();

      // Reload ch0 to 60, then saturate at capacity 100
      do_load(0, 100);
      do_reload(0, 60);
      check_val("rl_busy_e0", 32'(busy[0]), 1);
      repeat (7) cycle();
      check_val("rl_busy_e7", 32'(busy[0]), 1);
      check_val("rl_ammo_e7", 32'(ammo_of(0)), 0);
      cycle();
      check_val("rl_ammo_e8", 32'(ammo_of(0)), 60);
      check_val("rl_idle_e8", 32'(busy[0]), 0);
      do_reload(0, 60);
      repeat (8) cycle();
      check_val("rl_sat", 32'(ammo_of(0)), 100);
      do_load(0, 60);
      check_val("ld_clamp0", 32'(ammo_of(0)), 60);

      // Fire with cooldown 3 on ch0
      mode_selector = 4'b0010; fire_rate = 25; cooldown = 3;
      do_fire(0);
      check_val("fire1_fired", {30'd0, fired, error}, 2);
      check_val("fire1_ammo", 32'(ammo_of(0)), 35);
      for (int k = 0; k < 3; k++) begin
         do_fire(0);
         check_val("cool_err", {30'd0, fired, error}, 1);
         check_val("cool_ammo", 32'(ammo_of(0)), 35);
      end
      do_fire(0);
      check_val("fire2_ammo", 32'(ammo_of(0)), 10);
      check_val("fire2_fired", 32'(fired), 1);
      repeat (3) cycle();
      do_fire(0);
      check_val("fire3_sat0", 32'(ammo_of(0)), 0);
      repeat (3) cycle();
      do_fire(0);
      check_val("fire_empty_err", {30'd0, fired, error}, 1);

      // Load ch1..ch3 for the following tests
      do_load(1, 100); do_load(2, 100); do_load(3, 300);
      do_reload(1, 50); do_reload(2, 50); do_reload(3, 200);
      repeat (8) cycle();
      check_val("setup_ch1", 32'(ammo_of(1)), 50);
      check_val("setup_ch3", 32'(ammo_of(3)), 200);

      // Wrong mode
      mode_selector = 4'b0001;
      do_fire(1);
      check_val("mode_err", {30'd0, fired, error}, 1);
      check_val("mode_ammo", 32'(ammo_of(1)), 50);

      // reload_req pre-empts fire on ch1; ch2 fires back-to-back with no cooldown
      mode_selector = 4'b0010; fire_rate = 5; cooldown = 0;
      sel = 2'd1; reload_amt = 10; reload_req = 1'b1; fire = 1'b1;
      cycle();
      reload_req = 1'b0; fire = 1'b0;
      check_val("prio_err", {30'd0, fired, error}, 1);
      check_val("prio_ammo", 32'(ammo_of(1)), 50);
      check_val("prio_busy", 32'(busy[1]), 1);
      for (int k = 1; k <= 3; k++) begin
         do_fire(2);
         check_val("b2b_fired", {30'd0, fired, error}, 2);
         check_val("b2b_ammo", 32'(ammo_of(2)), 32'(50 - 5 * k));
      end
      repeat (5) cycle();
      check_val("prio_reload_done", 32'(ammo_of(1)), 60);

      // fire_rate 0 and capacity 0
      fire_rate = 0;
      do_fire(2);
      check_val("rate0_fired", 32'(fired), 1);
      check_val("rate0_ammo", 32'(ammo_of(2)), 35);
      do_load(2, 0);
      check_val("cap0_clamp", 32'(ammo_of(2)), 0);
      do_reload(2, 30);
      repeat (8) cycle();
      check_val("cap0_reload", 32'(ammo_of(2)), 0);

      // Capacity clamp on ch3, then sel=3 on both instances
      do_load(3, 50);
      check_val("ld_clamp3", 32'(ammo_of(3)), 50);
      fire_rate = 5;
      do_fire(3);
      check_val("sel3_nch4", {30'd0, fired, error}, 2);
      check_val("sel3_ammo", 32'(ammo_of(3)), 45);
      check_val("sel3_nch3", {30'd0, fired3, error3}, 1);

      // Asynchronous reset between edges during a reload
      do_reload(0, 20);
      cycle(); cycle();
      do_fire(3);
      check_val("pre_rst_fired", 32'(fired), 1);
      check_val("pre_rst_busy0", 32'(busy[0]), 1);
      #2 rst = 1'b0;
      #1;
      check_val("arst_ammo", 32'(ammo), 0);
      check_val("arst_busy", 32'(busy), 0);
      check_val("arst_fired_error", {30'd0, fired, error}, 0);
      #2 rst = 1'b1;
      cycle();
      do_load(0, 100);
      repeat (8) cycle();
      check_val("post_rst_ammo0", 32'(ammo_of(0)), 0);
      check_val("post_rst_busy0", 32'(busy[0]), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
